readout_scheduler: RTL and testbench



---
 rtl/readout_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_readout_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_scheduler.sv
// Round-robin readout scheduler for NGRP pixel priority-encoder groups; emits {group, addr} hits.
// Optional READOUT_TIMESTAMP_EN prepends an 8-bit frame-relative timestamp to each hit word.
module readout_scheduler #(
  parameter int unsigned NGRP   = 4,
  parameter int unsigned GW     = 2,
  parameter int unsigned AW     = 3,
  parameter int unsigned MAXHIT = 32,
`ifdef READOUT_TIMESTAMP_EN
  localparam int unsigned DW    = GW + AW + 8
`else
  localparam int unsigned DW    = GW + AW
`endif
) (
  input  logic               clk,
  input  logic               reset_readout,
  input  logic               frame_start,
  input  logic [NGRP-1:0]    grp_valid,
  input  logic [NGRP*AW-1:0] grp_addr,
  output logic [NGRP-1:0]    grp_read,
  output logic [NGRP-1:0]    grp_clr,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [DW-1:0]      hit_data,
  output logic               frame_busy,
  output logic               frame_done,
  output logic               hit_overflow,
  output logic [7:0]         hit_count
);

  typedef enum logic [2:0] {StIdle, StArb, StRead, StCapture, StEmit, StClear, StDone} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d, sel_q, sel_d;
  logic [NGRP-1:0] grp_read_q, grp_read_d, grp_clr_q, grp_clr_d;
  logic            hit_valid_q, hit_valid_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [DW-1:0]   hit_data_q, hit_data_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            found;
  logic [GW-1:0]   found_idx, sel_next;
  logic [AW-1:0]   cap_addr;
  int unsigned     idx;

`ifdef READOUT_TIMESTAMP_EN
  logic [7:0] ts_q, ts_d, ts_inc;
  assign ts_inc = (busy_q && ts_q != 8'hff) ? ts_q + 8'd1 : ts_q;
`endif

  // First pending group at or after ptr, wrapping modulo NGRP.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NGRP; i++) begin
      idx = (ptr_q + i) % NGRP;
      if (!found && grp_valid[GW'(idx)]) begin
        found     = 1'b1;
        found_idx = GW'(idx);
      end
    end
  end

  always_comb begin
    cap_addr = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      if (GW'(g) == sel_q) cap_addr = grp_addr[g*AW +: AW];
    end
  end

  assign sel_next = (sel_q == GW'(NGRP - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grp_read_d  = '0;
    grp_clr_d   = '0;
    hit_valid_d = hit_valid_q;
    hit_data_d  = hit_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
`ifdef READOUT_TIMESTAMP_EN
    ts_d        = ts_inc;
`endif
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StArb;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef READOUT_TIMESTAMP_EN
          ts_d    = '0;
`endif
        end
      end
      StArb: begin
        if (cnt_q == 8'(MAXHIT)) begin
          state_d = StDone;
          ovf_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (found) begin
          state_d    = StRead;
          sel_d      = found_idx;
          grp_read_d = NGRP'(1) << found_idx;
        end else begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
`ifdef READOUT_TIMESTAMP_EN
        hit_data_d = {ts_inc, sel_q, cap_addr};
`else
        hit_data_d = {sel_q, cap_addr};
`endif
        // The encoder may have withdrawn its hit during the read strobe.
        if (grp_valid[sel_q]) begin
          state_d     = StEmit;
          hit_valid_d = 1'b1;
        end else begin
          state_d = StArb;
          ptr_d   = sel_next;
        end
      end
      StEmit: begin
        if (hit_ready) begin
          state_d     = StClear;
          hit_valid_d = 1'b0;
          grp_clr_d   = NGRP'(1) << sel_q;
        end
      end
      StClear: begin
        state_d = StArb;
        cnt_d   = cnt_q + 8'd1;
        ptr_d   = sel_next;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_readout) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      sel_q       <= '0;
      grp_read_q  <= '0;
      grp_clr_q   <= '0;
      hit_valid_q <= 1'b0;
      hit_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef READOUT_TIMESTAMP_EN
      ts_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grp_read_q  <= grp_read_d;
      grp_clr_q   <= grp_clr_d;
      hit_valid_q <= hit_valid_d;
      hit_data_q  <= hit_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
`ifdef READOUT_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  assign grp_read     = grp_read_q;
  assign grp_clr      = grp_clr_q;
  assign hit_valid    = hit_valid_q;
  assign hit_data     = hit_data_q;
  assign frame_busy   = busy_q;
  assign frame_done   = done_q;
  assign hit_overflow = ovf_q;
  assign hit_count    = cnt_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// Bench for readout_scheduler: directed scenarios plus randomized frames against a queue-based
// model of the encoder groups and of the round-robin emission order.
module tb_readout_scheduler;

  localparam int NGRP = 4;
  localparam int GW   = 2;
  localparam int AW   = 3;
`ifdef READOUT_TIMESTAMP_EN
  localparam int DW   = GW + AW + 8;
`else
  localparam int DW   = GW + AW;
`endif

  logic               clk;
  logic               reset_readout;
  logic               frame_start;
  logic [NGRP-1:0]    grp_valid;
  logic [NGRP*AW-1:0] grp_addr;
  logic [NGRP-1:0]    grp_read;
  logic [NGRP-1:0]    grp_clr;
  logic               hit_valid;
  logic               hit_ready;
  logic [DW-1:0]      hit_data;
  logic               frame_busy;
  logic               frame_done;
  logic               hit_overflow;
  logic [7:0]         hit_count;

  // Second instance with MAXHIT=3 for the overflow scenario.
  logic               ov_frame_start;
  logic [NGRP-1:0]    ov_grp_valid;
  logic [NGRP*AW-1:0] ov_grp_addr;
  logic               ov_hit_ready;
  logic [NGRP-1:0]    ov_grp_read;
  logic [NGRP-1:0]    ov_grp_clr;
  logic               ov_hit_valid;
  logic [DW-1:0]      ov_hit_data;
  logic               ov_frame_busy;
  logic               ov_frame_done;
  logic               ov_hit_overflow;
  logic [7:0]         ov_hit_count;

  readout_scheduler #(.NGRP(NGRP), .GW(GW), .AW(AW), .MAXHIT(32)) dut (
    .clk(clk), .reset_readout(reset_readout), .frame_start(frame_start),
    .grp_valid(grp_valid), .grp_addr(grp_addr), .grp_read(grp_read), .grp_clr(grp_clr),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_data(hit_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .hit_overflow(hit_overflow),
    .hit_count(hit_count)
  );

  readout_scheduler #(.NGRP(NGRP), .GW(GW), .AW(AW), .MAXHIT(3)) dut_ov (
    .clk(clk), .reset_readout(reset_readout), .frame_start(ov_frame_start),
    .grp_valid(ov_grp_valid), .grp_addr(ov_grp_addr), .grp_read(ov_grp_read),
    .grp_clr(ov_grp_clr), .hit_valid(ov_hit_valid), .hit_ready(ov_hit_ready),
    .hit_data(ov_hit_data), .frame_busy(ov_frame_busy), .frame_done(ov_frame_done),
    .hit_overflow(ov_hit_overflow), .hit_count(ov_hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Encoder group model: per-group FIFO of pending pixel addresses.
  logic [AW-1:0]   pix [NGRP][64];
  int              head [NGRP];
  int              tail [NGRP];
  logic [NGRP-1:0] drop_mask;
  logic            flush;
  int              clr_pulses = 0;

  always @(negedge clk) begin
    int h;
    if (grp_clr != '0) clr_pulses <= clr_pulses + 1;
    for (int g = 0; g < NGRP; g++) begin
      h = head[g];
      if (flush) h = tail[g];
      else if (grp_clr[g] && h != tail[g]) h = h + 1;
      head[g]              <= h;
      grp_valid[g]         <= (h != tail[g]) && !drop_mask[g];
      grp_addr[g*AW +: AW] <= pix[g][h % 64];
    end
  end

  logic [GW+AW-1:0] exp_q[$];
  logic             exp_ovf;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic [AW-1:0] a);
    pix[g][tail[g] % 64] = a;
    tail[g] = tail[g] + 1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
  endtask

  // Emission order from the round-robin rule, computed over the pending FIFOs.
  task automatic build_expected(input int maxhit);
    int h[NGRP];
    int ptr, cnt, found;
    for (int g = 0; g < NGRP; g++) h[g] = head[g];
    exp_q.delete();
    ptr = 0;
    cnt = 0;
    while (cnt < maxhit) begin
      found = -1;
      for (int i = 0; i < NGRP; i++) begin
        if (found < 0 && h[(ptr + i) % NGRP] != tail[(ptr + i) % NGRP]) found = (ptr + i) % NGRP;
      end
      if (found < 0) break;
      exp_q.push_back({GW'(found), pix[found][h[found] % 64]});
      h[found]++;
      ptr = (found + 1) % NGRP;
      cnt++;
    end
    exp_ovf = (cnt == maxhit);
  endtask

  task automatic run_frame(input string tag, input bit rand_ready, input int spur_g);
    int n, clr0, spur_st;
    bit done_seen;
    n = 0;
    spur_st = 0;
    done_seen = 1'b0;
    clr0 = clr_pulses;
    hit_ready = 1'b1;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      hit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (spur_g >= 0 && spur_st == 0 && grp_read[spur_g]) begin
        drop_mask[spur_g] = 1'b1;
        spur_st = 1;
      end else if (spur_st == 1 && grp_read != '0) begin
        drop_mask = '0;
        spur_st = 2;
      end
      if (hit_valid && hit_ready) begin
        if (n < exp_q.size()) chk({tag, " hit word"}, 32'(hit_data[GW+AW-1:0]), 32'(exp_q[n]));
        else chk({tag, " excess hit"}, n, exp_q.size());
        n++;
      end
      if (frame_done) done_seen = 1'b1;
      else tick;
    end
    chk({tag, " frame_done seen"}, 32'(done_seen), 1);
    chk({tag, " hits emitted"}, n, exp_q.size());
    chk({tag, " hit_count"}, 32'(hit_count), exp_q.size());
    chk({tag, " hit_overflow"}, 32'(hit_overflow), 32'(exp_ovf));
    chk({tag, " busy at done"}, 32'(frame_busy), 0);
    chk({tag, " clear pulses"}, clr_pulses - clr0, n);
    if (spur_g >= 0) chk({tag, " spurious exercised"}, spur_st, 2);
    drop_mask = '0;
    hit_ready = 1'b1;
    tick;
  endtask

  task automatic wait_valid(input string tag);
    for (int c = 0; c < 20 && !hit_valid; c++) tick;
    chk({tag, " hit_valid reached"}, 32'(hit_valid), 1);
  endtask

  logic [DW-1:0] exp_d;
  logic [DW-1:0] held;
  int            c0, hits, clrs;
  bit            dn;

  initial begin
    reset_readout  = 1'b1;
    frame_start    = 1'b0;
    hit_ready      = 1'b1;
    drop_mask      = '0;
    flush          = 1'b0;
    ov_frame_start = 1'b0;
    ov_grp_valid   = 4'b0010;
    ov_grp_addr    = 12'o7654;
    ov_hit_ready   = 1'b1;
    repeat (3) tick;
    reset_readout = 1'b0;
    tick;

    chk("reset ctrl outputs", {grp_read, grp_clr, hit_valid, frame_busy, frame_done,
        hit_overflow}, 0);
    chk("reset hit_data", 32'(hit_data), 0);
    chk("reset hit_count", 32'(hit_count), 0);

    // Single hit with exact latency.
    push(2, 3'd5);
    tick;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("single busy cycle1", 32'(frame_busy), 1);
    tick;
    chk("single grp_read cycle2", 32'(grp_read), 4'b0100);
    tick;
    chk("single grp_read cycle3", 32'(grp_read), 0);
    tick;
`ifdef READOUT_TIMESTAMP_EN
    exp_d = {8'd3, 2'd2, 3'd5};
`else
    exp_d = {2'd2, 3'd5};
`endif
    chk("single hit_valid cycle4", 32'(hit_valid), 1);
    chk("single hit_data cycle4", 32'(hit_data), 32'(exp_d));
    tick;
    chk("single grp_clr cycle5", 32'(grp_clr), 4'b0100);
    chk("single hit_valid cycle5", 32'(hit_valid), 0);
    tick;
    tick;
    chk("single frame_done", 32'(frame_done), 1);
    chk("single hit_count", 32'(hit_count), 1);
    chk("single busy at done", 32'(frame_busy), 0);
    tick;
    chk("single done one cycle", 32'(frame_done), 0);

    // Round robin, two hits per group.
    for (int k = 0; k < 2; k++)
      for (int g = 0; g < NGRP; g++) push(g, 3'($urandom_range(0, 7)));
    tick;
    build_expected(32);
    run_frame("roundrobin", 1'b0, -1);

    // Backpressure in EMIT.
    push(0, 3'd3);
    tick;
    hit_ready = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    wait_valid("bp");
    held = hit_data;
    chk("bp hit word", 32'(hit_data[GW+AW-1:0]), 32'({2'd0, 3'd3}));
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("bp held stable", {hit_valid, grp_clr, 32'(held)}, {1'b1, 4'b0, 32'(hit_data)});
    end
    hit_ready = 1'b1;
    tick;
    chk("bp valid after handshake", 32'(hit_valid), 0);
    chk("bp clear after handshake", 32'(grp_clr), 4'b0001);
    for (int c = 0; c < 20 && !frame_done; c++) tick;
    chk("bp frame_done", 32'(frame_done), 1);
    chk("bp hit_count", 32'(hit_count), 1);
    tick;

    // Reset while a hit is waiting in EMIT.
    push(1, 3'd2);
    tick;
    hit_ready = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    wait_valid("rst");
    c0 = clr_pulses;
    reset_readout = 1'b1;
    tick;
    reset_readout = 1'b0;
    chk("rst ctrl outputs", {grp_read, grp_clr, hit_valid, frame_busy, frame_done,
        hit_overflow}, 0);
    chk("rst hit_data", 32'(hit_data), 0);
    chk("rst hit_count", 32'(hit_count), 0);
    hit_ready = 1'b1;
    repeat (6) tick;
    chk("rst no clear pulse", clr_pulses - c0, 0);
    chk("rst stays idle", 32'(frame_busy), 0);
    do_flush;

    // Spurious: group 3 withdraws during its read strobe.
    push(0, 3'd1);
    push(0, 3'd2);
    push(3, 3'd4);
    tick;
    exp_q.delete();
    exp_q.push_back({2'd0, 3'd1});
    exp_q.push_back({2'd0, 3'd2});
    exp_q.push_back({2'd3, 3'd4});
    exp_ovf = 1'b0;
    run_frame("spurious", 1'b0, 3);
    do_flush;

    // Randomized frames; the first one is guaranteed to hit MAXHIT.
    for (int f = 0; f < 6; f++) begin
      for (int g = 0; g < NGRP; g++) begin
        int k;
        k = (f == 0) ? 9 : $urandom_range(0, 10);
        for (int j = 0; j < k; j++) push(g, 3'($urandom_range(0, 7)));
      end
      tick;
      build_expected(32);
      run_frame("random", 1'b1, -1);
      do_flush;
    end

    // Overflow at MAXHIT=3 with a mid-frame frame_start.
    ov_frame_start = 1'b1;
    tick;
    ov_frame_start = 1'b0;
    hits = 0;
    clrs = 0;
    dn = 1'b0;
    for (int c = 0; c < 100 && !dn; c++) begin
      ov_frame_start = (c == 7);
      if (ov_hit_valid) hits++;
      if (ov_grp_clr != '0) clrs++;
      if (ov_frame_done) dn = 1'b1;
      else tick;
    end
    ov_frame_start = 1'b0;
    chk("ovf frame_done", 32'(dn), 1);
    chk("ovf hits", hits, 3);
    chk("ovf clears", clrs, 3);
    chk("ovf hit_overflow", 32'(ov_hit_overflow), 1);
    chk("ovf hit_count", 32'(ov_hit_count), 3);
    tick;
    ov_frame_start = 1'b1;
    tick;
    ov_frame_start = 1'b0;
    chk("ovf cleared on restart", 32'(ov_hit_overflow), 0);
    chk("ovf count cleared", 32'(ov_hit_count), 0);
    for (int c = 0; c < 100 && !ov_frame_done; c++) tick;
    chk("ovf second frame done", 32'(ov_frame_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
